// File: rtl/sram_frame_arbiter_if.sv
// Requester and SRAM pin bundle for sram_frame_arbiter.
// The arbiter takes the slave side; requesters and pin drivers take the master side.
interface sram_frame_arbiter_if;
    logic        i_a_req;
    logic [19:0] i_a_addr;
    logic        o_a_ack;
    logic [15:0] o_a_rdata;
    logic        o_a_rvalid;

    logic        i_b_req;
    logic        i_b_we;
    logic [19:0] i_b_addr;
    logic [15:0] i_b_wdata;
    logic [1:0]  i_b_be;
    logic        o_b_ack;
    logic [15:0] o_b_rdata;
    logic        o_b_rvalid;

    logic [19:0] o_sram_addr;
    logic        o_sram_ce_n;
    logic        o_sram_oe_n;
    logic        o_sram_we_n;
    logic        o_sram_lb_n;
    logic        o_sram_ub_n;

    modport slave (
        input  i_a_req, i_a_addr, i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be,
        output o_a_ack, o_a_rdata, o_a_rvalid, o_b_ack, o_b_rdata, o_b_rvalid,
        output o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
    );

    modport master (
        output i_a_req, i_a_addr, i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be,
        input  o_a_ack, o_a_rdata, o_a_rvalid, o_b_ack, o_b_rdata, o_b_rvalid,
        input  o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
    );
endinterface

// File: rtl/sram_frame_arbiter.sv
// Two-port arbiter for an asynchronous 1Mx16 SRAM: port A (video fetch, priority)
// and port B (draw logic, read/write) with a streak limit so B cannot starve.
module sram_frame_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_A_BURST   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sram_frame_arbiter_if.slave  bus,
    inout  wire [15:0]           io_sram_dq
);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int SW = $clog2(MAX_A_BURST + 1);

    typedef enum logic [1:0] {IDLE, ACC_A, ACC_B} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          cur_we;
    logic          dq_oe;
    logic [15:0]   dq_out;

    logic last, decide, b_wins, grant_a, grant_b, new_we;

    assign last    = (state != IDLE) && (cnt == CW'(ACCESS_CYCLES - 1));
    assign decide  = (state == IDLE) || last;
    // B overrides A only once A has used its full streak while B waited
    assign b_wins  = bus.i_b_req && (!bus.i_a_req || streak == SW'(MAX_A_BURST));
    assign grant_a = decide && bus.i_a_req && !b_wins;
    assign grant_b = decide && b_wins;
    assign new_we  = grant_b && bus.i_b_we;

    assign io_sram_dq = dq_oe ? dq_out : {16{1'bz}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            streak          <= '0;
            cur_we          <= 1'b0;
            dq_oe           <= 1'b0;
            dq_out          <= '0;
            bus.o_a_ack     <= 1'b0;
            bus.o_a_rdata   <= '0;
            bus.o_a_rvalid  <= 1'b0;
            bus.o_b_ack     <= 1'b0;
            bus.o_b_rdata   <= '0;
            bus.o_b_rvalid  <= 1'b0;
            bus.o_sram_addr <= '0;
            bus.o_sram_ce_n <= 1'b1;
            bus.o_sram_oe_n <= 1'b1;
            bus.o_sram_we_n <= 1'b1;
            bus.o_sram_lb_n <= 1'b1;
            bus.o_sram_ub_n <= 1'b1;
        end else begin
            bus.o_a_ack    <= grant_a;
            bus.o_b_ack    <= grant_b;
            bus.o_a_rvalid <= 1'b0;
            bus.o_b_rvalid <= 1'b0;

            if (!bus.i_b_req || grant_b)
                streak <= '0;
            else if (grant_a && streak != SW'(MAX_A_BURST))
                streak <= streak + 1'b1;

            // read data is captured while oe_n is still low on the final edge
            if (last && !cur_we) begin
                if (state == ACC_A) begin
                    bus.o_a_rdata  <= io_sram_dq;
                    bus.o_a_rvalid <= 1'b1;
                end else begin
                    bus.o_b_rdata  <= io_sram_dq;
                    bus.o_b_rvalid <= 1'b1;
                end
            end

            if (grant_a || grant_b) begin
                state           <= grant_a ? ACC_A : ACC_B;
                cnt             <= '0;
                cur_we          <= new_we;
                bus.o_sram_addr <= grant_a ? bus.i_a_addr : bus.i_b_addr;
                bus.o_sram_ce_n <= 1'b0;
                bus.o_sram_oe_n <= new_we;
                bus.o_sram_we_n <= !new_we;
                bus.o_sram_lb_n <= new_we ? !bus.i_b_be[0] : 1'b0;
                bus.o_sram_ub_n <= new_we ? !bus.i_b_be[1] : 1'b0;
                dq_oe           <= new_we;
                dq_out          <= bus.i_b_wdata;
            end else if (last) begin
                state           <= IDLE;
                cnt             <= '0;
                cur_we          <= 1'b0;
                bus.o_sram_ce_n <= 1'b1;
                bus.o_sram_oe_n <= 1'b1;
                bus.o_sram_we_n <= 1'b1;
                bus.o_sram_lb_n <= 1'b1;
                bus.o_sram_ub_n <= 1'b1;
                dq_oe           <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
                // we_n rises one cycle before the end so addr/data hold past it
                if (cnt == CW'(ACCESS_CYCLES - 2))
                    bus.o_sram_we_n <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Scoreboard bench for sram_frame_arbiter with a behavioural async SRAM on the pins.
module tb_sram_frame_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    wire [15:0] sram_dq;

    sram_frame_arbiter_if sif();

    sram_frame_arbiter #(.ACCESS_CYCLES(2), .MAX_A_BURST(4)) dut (
        .i_clk(clk), .i_rst(rst), .bus(sif), .io_sram_dq(sram_dq)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    logic [15:0] mem [0:(1<<20)-1];
    logic [15:0] ref_mem [logic [19:0]];
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    bit          grant_log[$];
    int          b_ack_cyc[$];
    int          a_ack_last = 0;
    int          b_rv_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    task automatic preload(input logic [19:0] a, input logic [15:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    // SRAM model: drives reads, captures writes while we_n is low
    assign sram_dq = (!sif.o_sram_ce_n && !sif.o_sram_oe_n && sif.o_sram_we_n)
                     ? mem[sif.o_sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sif.o_sram_ce_n && !sif.o_sram_we_n) begin
            if (!sif.o_sram_lb_n) mem[sif.o_sram_addr][7:0]  <= sram_dq[7:0];
            if (!sif.o_sram_ub_n) mem[sif.o_sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    // scoreboard: expectations pushed as requests are accepted, popped on rvalid
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.o_a_ack) begin
                grant_log.push_back(1'b0);
                a_ack_last = cyc;
                qa.push_back(ref_rd(sif.i_a_addr));
            end
            if (sif.o_b_ack) begin
                logic [15:0] w;
                grant_log.push_back(1'b1);
                b_ack_cyc.push_back(cyc);
                if (sif.i_b_we) begin
                    w = ref_rd(sif.i_b_addr);
                    if (sif.i_b_be[0]) w[7:0]  = sif.i_b_wdata[7:0];
                    if (sif.i_b_be[1]) w[15:8] = sif.i_b_wdata[15:8];
                    ref_mem[sif.i_b_addr] = w;
                end else begin
                    qb.push_back(ref_rd(sif.i_b_addr));
                end
            end
            if (sif.o_a_rvalid) begin
                if (qa.size() == 0) chk("a_spurious_rvalid", 1, 0);
                else chk("a_rdata", {16'h0, sif.o_a_rdata}, {16'h0, qa.pop_front()});
            end
            if (sif.o_b_rvalid) begin
                b_rv_cnt++;
                if (qb.size() == 0) chk("b_spurious_rvalid", 1, 0);
                else chk("b_rdata", {16'h0, sif.o_b_rdata}, {16'h0, qb.pop_front()});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit port_b, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(port_b ? sif.o_b_ack : sif.o_a_ack) && n < 60);
        if (!(port_b ? sif.o_b_ack : sif.o_a_ack)) chk({tag, "_ack_timeout"}, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic b_issue(input logic we, input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        sif.i_b_req   = 1'b1;
        sif.i_b_we    = we;
        sif.i_b_addr  = a;
        sif.i_b_wdata = d;
        sif.i_b_be    = be;
    endtask

    function automatic logic [4:0] strobes();
        return {sif.o_sram_ce_n, sif.o_sram_oe_n, sif.o_sram_we_n, sif.o_sram_lb_n, sif.o_sram_ub_n};
    endfunction

    initial begin
        int rv0;
        sif.i_a_req = 1'b0; sif.i_a_addr = '0;
        sif.i_b_req = 1'b0; sif.i_b_we = 1'b0; sif.i_b_addr = '0;
        sif.i_b_wdata = '0; sif.i_b_be = 2'b11;
        preload(20'h00010, 16'hBEEF);
        preload(20'h12345, 16'h1234);
        preload(20'h00020, 16'h2020);
        for (int i = 0; i < 8; i++) preload(20'h00300 + 20'(i), 16'h5000 + 16'(i * 3));

        // reset state
        idle(3);
        chk("rst_strobes", {27'h0, strobes()}, 32'h1F);
        chk("rst_addr", {12'h0, sif.o_sram_addr}, 0);
        chk("rst_acks", {30'h0, sif.o_a_ack, sif.o_b_ack}, 0);
        chk("rst_rvalids", {30'h0, sif.o_a_rvalid, sif.o_b_rvalid}, 0);
        chk("rst_rdata", {sif.o_a_rdata, sif.o_b_rdata}, 0);
        rst = 1'b0;
        idle(2);

        // A read: ack at t, oe_n low t and t+1, rvalid at t+2
        sif.i_a_req = 1'b1; sif.i_a_addr = 20'h00010;
        wait_ack(1'b0, "a_read");
        sif.i_a_req = 1'b0;
        chk("a_rd_strobes_t0", {27'h0, strobes()}, 32'h04);
        chk("a_rd_addr", {12'h0, sif.o_sram_addr}, 32'h00010);
        step();
        chk("a_rd_oe_t1", {31'h0, sif.o_sram_oe_n}, 0);
        chk("a_rd_rvalid_t1", {31'h0, sif.o_a_rvalid}, 0);
        step();
        chk("a_rd_rvalid_t2", {31'h0, sif.o_a_rvalid}, 1);
        chk("a_rd_idle_strobes", {27'h0, strobes()}, 32'h1F);
        idle(2);

        // B byte write then read back
        b_issue(1'b1, 20'h12345, 16'hA55A, 2'b01);
        wait_ack(1'b1, "b_write");
        sif.i_b_req = 1'b0;
        chk("b_wr_strobes_t0", {27'h0, strobes()}, 32'h09);
        chk("b_wr_dq_t0", {16'h0, sram_dq}, 32'hA55A);
        step();
        chk("b_wr_strobes_t1", {27'h0, strobes()}, 32'h0D);
        chk("b_wr_dq_t1", {16'h0, sram_dq}, 32'hA55A);
        step();
        chk("b_wr_done", {27'h0, strobes()}, 32'h1F);
        b_issue(1'b0, 20'h12345, 16'h0, 2'b11);
        wait_ack(1'b1, "b_readback");
        sif.i_b_req = 1'b0;
        idle(4);

        // both held continuously: A,A,A,A,B repeating
        grant_log.delete();
        sif.i_a_req = 1'b1; sif.i_a_addr = 20'h00010;
        b_issue(1'b0, 20'h00020, 16'h0, 2'b11);
        for (int n = 0; n < 80 && grant_log.size() < 10; n++) step();
        sif.i_a_req = 1'b0; sif.i_b_req = 1'b0;
        if (grant_log.size() < 10) chk("grant_order_timeout", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), {31'h0, grant_log[i]}, (i % 5 == 4) ? 1 : 0);
        idle(6);

        // B alone: 8 back-to-back reads
        b_ack_cyc.delete();
        rv0 = b_rv_cnt;
        for (int i = 0; i < 8; i++) begin
            b_issue(1'b0, 20'h00300 + 20'(i), 16'h0, 2'b11);
            wait_ack(1'b1, "b_burst");
        end
        sif.i_b_req = 1'b0;
        idle(4);
        for (int i = 1; i < 8 && i < b_ack_cyc.size(); i++)
            chk($sformatf("b_burst_gap_%0d", i), b_ack_cyc[i] - b_ack_cyc[i-1], 2);
        chk("b_burst_rvalids", b_rv_cnt - rv0, 8);

        // simultaneous A and B from idle
        b_ack_cyc.delete();
        sif.i_a_req = 1'b1; sif.i_a_addr = 20'h00010;
        b_issue(1'b0, 20'h00303, 16'h0, 2'b11);
        wait_ack(1'b0, "simul_a");
        sif.i_a_req = 1'b0;
        chk("simul_b_not_first", {31'h0, sif.o_b_ack}, 0);
        wait_ack(1'b1, "simul_b");
        sif.i_b_req = 1'b0;
        if (b_ack_cyc.size() > 0) chk("simul_b_delay", b_ack_cyc[0] - a_ack_last, 2);
        else chk("simul_b_missing", 0, 1);
        idle(4);

        // reset in the middle of a write aborts immediately
        rv0 = b_rv_cnt;
        b_issue(1'b1, 20'h00400, 16'h7777, 2'b11);
        wait_ack(1'b1, "b_wr_abort");
        sif.i_b_req = 1'b0;
        chk("abort_we_low", {31'h0, sif.o_sram_we_n}, 0);
        rst = 1'b1;
        #1;
        chk("abort_strobes", {27'h0, strobes()}, 32'h1F);
        step();
        rst = 1'b0;
        idle(5);
        chk("abort_no_rvalid", b_rv_cnt - rv0, 0);
        chk("scoreboard_drained", qa.size() + qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
